button_irq_ctrl: RTL and testbench
==================================

Name: button_irq_ctrl

Overview:
- Consumes the four debounced button levels produced by the button-debounce stage.
- Detects selectable rising or falling edges and long presses for each button, and latches them as pending events.
- Pending events are masked by a software enable register and drive one registered interrupt line to the CPU.
- Control and status registers sit on the simple SoC peripheral bus (addr/wr/rd strobes, 32-bit data).

Parameters:
NUM_BUTTONS, 4, number of button inputs; fixed at 4 for the register map below.
LONG_PRESS_CYCLES, 50000000, consecutive high cycles of a level that qualify as a long press (1 s at 50 MHz); must be ≥2.
CNT_W, $clog2(LONG_PRESS_CYCLES+1), hold-counter width.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST_N  in  1  asynchronous active-low reset.
btn_level  in  4  debounced button levels, synchronous to CLK; 1 = pressed.
bus_addr  in  2  register word address.
bus_wr  in  1  write strobe, one cycle.
bus_rd  in  1  read strobe, one cycle.
bus_wdata  in  32  write data.
bus_rdata  out  32  read data.
bus_rvalid  out  1  read data valid.
irq  out  1  level interrupt to the CPU.

Behaviour:
- Reset (async assert, sync-released by the system):
  - All registers go to 0: btn_q, hold counters, PENDING, ENABLE, EDGE_SEL, irq, bus_rdata, bus_rvalid.
  - Reset mid-press: the counter clears; no event is generated for that press until release and re-press.
- btn_q is btn_level registered once per cycle.
  - rise[i] = btn_level[i] & ~btn_q[i].
  - fall[i] = ~btn_level[i] & btn_q[i].
  - press_evt[i] = EDGE_SEL[i] ? fall[i] : rise[i].
- Hold counter, per button:
  - Clears whenever btn_level[i] = 0.
  - Increments while btn_level[i] = 1; saturates at LONG_PRESS_CYCLES.
  - long_evt[i] fires for one cycle on the edge where the count goes LONG_PRESS_CYCLES-1 → LONG_PRESS_CYCLES, i.e. once per press.
- PENDING[3:0] = press events, PENDING[7:4] = long events.
  - A bit sets on the clock edge following the cycle in which its event is true.
  - Write-1-to-clear via bus.
  - If set and clear hit the same bit in the same cycle, set wins.
- irq register:
  - irq <= |(PENDING & ENABLE), so irq rises one cycle after the pending bit.
  - Latency from the first cycle btn_level=1 to irq=1 is 2 clock edges.
  - Writing ENABLE or clearing PENDING takes effect on irq one cycle later.
- Register map (word addresses); unused bits read 0:
  - 0 STATUS (RO): [3:0] = btn_q.
  - 1 PENDING (RW1C): [7:0].
  - 2 ENABLE (RW): [7:0].
  - 3 EDGE_SEL (RW): [3:0].
- Bus rules:
  - Writes apply on the strobe edge; writes to STATUS are ignored.
  - Reads: bus_rdata and bus_rvalid are registered. The value is valid in the cycle after bus_rd, and bus_rvalid pulses high for exactly that cycle.
  - A read returns the register value before any same-cycle write.
  - bus_rd and bus_wr together is legal; both are serviced.
- Changing EDGE_SEL does not create a spurious event; events derive only from btn_level vs btn_q.

Decomposition:
- Package btn_irq_pkg holds:
  - NUM_BUTTONS.
  - Register address localparams ADDR_STATUS=0, ADDR_PENDING=1, ADDR_ENABLE=2, ADDR_EDGE_SEL=3.
  - Bit-field offsets PEND_PRESS_LSB=0, PEND_LONG_LSB=4.
- Sub-module btn_hold_counter (CLK, RST_N, level, long_evt), parameterised by LONG_PRESS_CYCLES, instantiated once per button.
- Edge detection, registers, bus decode and irq stay in the top module.

Test Plan (bench uses LONG_PRESS_CYCLES=8):
- Reset, then read addr 0..3 → bus_rvalid pulses 1 cycle after bus_rd with rdata 0 each time; irq=0.
- Write ENABLE=0x01, raise btn_level[0] for 3 cycles → PENDING=0x01 one edge after rise, irq=1 the edge after that; write PENDING=0x01 → irq=0 one cycle later.
- Write EDGE_SEL=0x2, ENABLE=0x02, pulse btn_level[1] high 4 cycles → PENDING stays 0 until the falling edge, then PENDING=0x02 and irq=1.
- Hold btn_level[2] high 20 cycles with ENABLE=0x40 → PENDING[6] sets exactly once on the 8th high cycle and PENDING[2] sets at press; irq=1 only after PENDING[6]; releasing for 5 cycles and re-pressing → second long event only after 8 more high cycles.
- Write-1-to-clear PENDING[0] in the same cycle as a new rise on button 0 → PENDING[0] reads 1 (set wins).
- Assert RST_N=0 mid long-press at count 5, release reset, keep button high → no long event until button released and re-held 8 cycles; STATUS reads 0x4 while held.

Source files
------------

// File: rtl/btn_irq_pkg.sv
// Shared constants for the button interrupt controller: button count, register map, PENDING layout.
package btn_irq_pkg;

  localparam int unsigned NUM_BUTTONS = 4;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_ENABLE   = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  localparam int unsigned PEND_PRESS_LSB = 0;
  localparam int unsigned PEND_LONG_LSB  = 4;

endpackage

// File: rtl/btn_hold_counter.sv
// Per-button hold counter: pulses long_evt once per press after LONG_PRESS_CYCLES high cycles.
module btn_hold_counter #(
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic level,
  output logic long_evt
);

  localparam int unsigned CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Armed only after the level has been seen low, so a press already in
  // progress across a reset never produces a long event.
  logic armed_q, armed_d;

  // Next-state: clear on release, count while held and armed, saturate at the limit.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!level) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose edge moves the count from LAST to MAX.
  assign long_evt = level & armed_q & (cnt_q == LastCnt);

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/button_irq_ctrl.sv
// Button interrupt controller: edge / long-press detection, pending/enable registers, bus, irq.
module button_irq_ctrl
  import btn_irq_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  btn_level,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        irq
);

  logic [3:0]  btn_q;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  enable_q, enable_d;
  logic [3:0]  edge_sel_q, edge_sel_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  logic [3:0] rise, fall, press_evt, long_evt;
  logic [7:0] set_bits, clr_bits;

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:8];

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_hold
    btn_hold_counter #(
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_hold (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .level   (btn_level[i]),
      .long_evt(long_evt[i])
    );
  end

  assign rise      = btn_level & ~btn_q;
  assign fall      = ~btn_level & btn_q;
  assign press_evt = (edge_sel_q & fall) | (~edge_sel_q & rise);

  // Register next-state: bus writes, pending set/clear (set has priority), irq.
  always_comb begin
    set_bits = '0;
    set_bits[PEND_PRESS_LSB +: 4] = press_evt;
    set_bits[PEND_LONG_LSB +: 4]  = long_evt;

    clr_bits   = '0;
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    if (bus_wr) begin
      case (bus_addr)
        ADDR_PENDING:  clr_bits   = bus_wdata[7:0];
        ADDR_ENABLE:   enable_d   = bus_wdata[7:0];
        ADDR_EDGE_SEL: edge_sel_d = bus_wdata[3:0];
        default:       ;
      endcase
    end

    pending_d = (pending_q & ~clr_bits) | set_bits;
    irq_d     = |(pending_q & enable_q);
  end

  // Read mux: samples pre-write register values.
  always_comb begin
    rdata_d = '0;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_STATUS:   rdata_d[3:0] = btn_q;
        ADDR_PENDING:  rdata_d[7:0] = pending_q;
        ADDR_ENABLE:   rdata_d[7:0] = enable_q;
        ADDR_EDGE_SEL: rdata_d[3:0] = edge_sel_q;
        default:       ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      btn_q      <= btn_level;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= bus_rd;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Directed bench for button_irq_ctrl with LONG_PRESS_CYCLES = 8.
module tb_button_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn_level;
  logic [1:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  button_irq_ctrl #(
    .LONG_PRESS_CYCLES(8)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .btn_level (btn_level),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    bus_wr    = 1'b1;
    bus_addr  = a;
    bus_wdata = wd;
    tick();
    bus_wr    = 1'b0;
  endtask

  // One-cycle read strobe; returns data from the following cycle.
  task automatic do_read(input logic [1:0] a, input string tag, output logic [31:0] data);
    bus_rd   = 1'b1;
    bus_addr = a;
    tick();
    bus_rd   = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, bus_rvalid}, 32'd1);
    data = bus_rdata;
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    do_read(a, tag, v);
    chk(tag, v, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_level = '0;
    bus_addr  = '0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = '0;
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset contents of every register.
    for (int a = 0; a < 4; a++) begin
      rd_check(2'(a), 32'd0, $sformatf("rst_reg%0d", a));
      tick();
      chk($sformatf("rst_rvalid_drop%0d", a), {31'd0, bus_rvalid}, 32'd0);
    end
    chk("rst_irq_after_reads", {31'd0, irq}, 32'd0);

    // Rising edge on button 0 with ENABLE[0].
    bus_write(2'd2, 32'h01);
    btn_level[0] = 1'b1;
    tick();
    chk("t2_irq_edge1", {31'd0, irq}, 32'd0);
    rd_check(2'd1, 32'h01, "t2_pending");
    chk("t2_irq_edge2", {31'd0, irq}, 32'd1);
    tick();
    btn_level[0] = 1'b0;
    bus_write(2'd1, 32'h01);
    chk("t2_irq_hold", {31'd0, irq}, 32'd1);
    tick();
    chk("t2_irq_cleared", {31'd0, irq}, 32'd0);

    // Falling-edge select on button 1.
    bus_write(2'd3, 32'h2);
    bus_write(2'd2, 32'h02);
    btn_level[1] = 1'b1;
    rd_check(2'd1, 32'h00, "t3_no_rise_evt");
    repeat (3) tick();
    chk("t3_irq_while_held", {31'd0, irq}, 32'd0);
    btn_level[1] = 1'b0;
    tick();
    chk("t3_irq_fall_edge", {31'd0, irq}, 32'd0);
    rd_check(2'd1, 32'h02, "t3_pending_fall");
    chk("t3_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h0);
    rd_check(2'd3, 32'h0, "t3_edge_sel_back");

    // Long press on button 2.
    bus_write(2'd2, 32'h40);
    tick();
    chk("t4_irq_idle", {31'd0, irq}, 32'd0);
    btn_level[2] = 1'b1;
    tick();
    chk("t4_irq_c1", {31'd0, irq}, 32'd0);
    rd_check(2'd1, 32'h04, "t4_press_only");
    for (int c = 3; c <= 8; c++) begin
      tick();
      chk($sformatf("t4_irq_c%0d", c), {31'd0, irq}, 32'd0);
    end
    rd_check(2'd1, 32'h44, "t4_long_evt");
    chk("t4_irq_long", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h40);
    repeat (9) tick();
    rd_check(2'd1, 32'h04, "t4_long_once");
    chk("t4_irq_after_clear", {31'd0, irq}, 32'd0);
    btn_level[2] = 1'b0;
    repeat (5) tick();
    btn_level[2] = 1'b1;
    repeat (7) tick();
    rd_check(2'd1, 32'h04, "t4_repress_h8");
    chk("t4_repress_irq_h8", {31'd0, irq}, 32'd0);
    rd_check(2'd1, 32'h44, "t4_repress_long");
    chk("t4_repress_irq", {31'd0, irq}, 32'd1);
    btn_level[2] = 1'b0;
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'h00);

    // Same-cycle set and write-1-to-clear on PENDING[0].
    btn_level[0] = 1'b1;
    bus_write(2'd1, 32'h01);
    rd_check(2'd1, 32'h01, "t5_set_wins");
    btn_level[0] = 1'b0;
    tick();
    bus_write(2'd1, 32'hFF);
    tick();

    // Reset in the middle of a long press.
    btn_level[2] = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_irq_in_reset", {31'd0, irq}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_check(2'd0, 32'h4, "t6_status_held");
    repeat (15) tick();
    do_read(2'd1, "t6_no_long", d);
    chk("t6_no_long", {28'd0, d[7:4]}, 32'h0);
    btn_level[2] = 1'b0;
    repeat (2) tick();
    btn_level[2] = 1'b1;
    repeat (7) tick();
    do_read(2'd1, "t6_rehold_h8", d);
    chk("t6_rehold_h8", {28'd0, d[7:4]}, 32'h0);
    do_read(2'd1, "t6_rehold_long", d);
    chk("t6_rehold_long", {28'd0, d[7:4]}, 32'h4);
    btn_level[2] = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
